vga_pixel_gen: RTL

VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

---
 rtl/vga_pixel_gen_if.sv | 22 ++
 rtl/vga_pixel_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen_if.sv
// Framebuffer row-write handshake between a row producer (master) and
// vga_pixel_gen (slave).
interface vga_pixel_gen_if;
    logic        wr_valid;
    logic [3:0]  wr_row;
    logic [31:0] wr_data;
    logic        wr_ready;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vga_pixel_gen.sv
// Two-stage pixel generator: 16x32 one-bit cell framebuffer, fg/bg palette,
// row writes deferred off the displayed row. Define VGA_CURSOR_EN for the blinking cursor.
module vga_pixel_gen (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [5:0]     x_hi,
    input  logic [4:0]     x_lo,
    input  logic [4:0]     y_hi,
    input  logic [5:0]     y_lo,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic           blank_in,
    vga_pixel_gen_if.slave wr,
    input  logic           cfg_we,
    input  logic           cfg_sel,
    input  logic [5:0]     cfg_color,
    input  logic [3:0]     cursor_row,
    input  logic [4:0]     cursor_col,
    output logic [5:0]     rgb,
    output logic           hsync_out,
    output logic           vsync_out
);
    localparam int ROWS  = 16;
    localparam int COLS  = 32;
    localparam int COLOR_W = 6;

    logic [COLS-1:0]    fb [ROWS];
    logic               pending;
    logic [3:0]         pend_row;
    logic [COLS-1:0]    pend_data;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;

    logic [3:0] cell_row;
    logic [4:0] cell_col;
    logic       cell_bit;
    logic       wr_fire;
    logic       commit;
    logic       cursor_inv;

    logic       cell_p1, blank_p1, hs_p1, vs_p1, cur_p1;
    logic [COLOR_W-1:0] rgb_p2;
    logic       hs_p2, vs_p2;

    function automatic logic [COLOR_W-1:0] pixel_color(
        input logic               blank,
        input logic               lit,
        input logic [COLOR_W-1:0] fg_c,
        input logic [COLOR_W-1:0] bg_c
    );
        if (blank)
            return '0;
        return lit ? fg_c : bg_c;
    endfunction

    assign cell_row = y_hi[3:0];
    assign cell_col = x_hi[4:0];
    assign cell_bit = fb[cell_row][cell_col];

    assign wr.wr_ready = ~pending;
    assign wr_fire     = wr.wr_valid & ~pending;
    // Only commit while the target row is not being scanned, so a line never tears.
    assign commit      = pending & (blank_in | (cell_row != pend_row));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (commit)
            pending <= 1'b0;
        else if (wr_fire)
            pending <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            pend_row  <= wr.wr_row;
            pend_data <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                fb[r] <= '0;
        end else if (commit) begin
            fb[pend_row] <= pend_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg <= 6'h3F;
            bg <= 6'h00;
        end else if (cfg_we) begin
            if (cfg_sel)
                fg <= cfg_color;
            else
                bg <= cfg_color;
        end
    end

`ifdef VGA_CURSOR_EN
    logic [4:0] frame_cnt;
    logic       unused_bits;

    // vs_p1 holds last cycle's vsync_in, so this catches the 1->0 edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (!vsync_in && vs_p1)
            frame_cnt <= frame_cnt + 5'd1;
    end

    assign cursor_inv  = frame_cnt[4] && (cell_row == cursor_row) && (cell_col == cursor_col);
    assign unused_bits = ^{x_lo, y_lo, x_hi[5], y_hi[4]};
`else
    logic unused_bits;

    assign cursor_inv  = 1'b0;
    assign unused_bits = ^{x_lo, y_lo, x_hi[5], y_hi[4], cursor_row, cursor_col};
`endif

    // Stage 1: cell lookup and timing capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_p1  <= 1'b0;
            blank_p1 <= 1'b1;
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            cur_p1   <= 1'b0;
        end else begin
            cell_p1  <= cell_bit;
            blank_p1 <= blank_in;
            hs_p1    <= hsync_in;
            vs_p1    <= vsync_in;
            cur_p1   <= cursor_inv;
        end
    end

    // Stage 2: colour resolve, syncs realigned with pixel data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p2 <= '0;
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
        end else begin
            rgb_p2 <= pixel_color(blank_p1, cell_p1 ^ cur_p1, fg, bg);
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    assign rgb       = rgb_p2;
    assign hsync_out = hs_p2;
    assign vsync_out = vs_p2;
endmodule
